btb_assoc_predictor: RTL and testbench

Parametrised, tagged, set-associative branch target buffer with per-entry saturating direction counters. It is the next generation of the direct-mapped target buffer. It gives IF a combinational target/taken prediction for the fetch PC. It is trained from EX with resolved branch outcomes, for both taken and not-taken branches. Adds tags, associativity, round-robin replacement, hysteresis and a flush.

---
 rtl/btb_assoc_predictor.sv | 158 +++++++++++++++
 tb/tb_btb_assoc_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_predictor.sv
// Set-associative, tagged branch target buffer with saturating direction counters.
// Lookup is combinational off the fetch PC; training from resolved branches happens on the clock edge.
module btb_assoc_predictor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned CNT_WIDTH   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    input  logic [PC_WIDTH-1:0] lookup_pc_plus4,
    output logic [PC_WIDTH-1:0] pred_target,
    output logic                pred_taken,
    output logic                pred_hit,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target,
    input  logic                flush
);

    localparam int unsigned SETS      = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH = PC_WIDTH - INDEX_WIDTH - 2;
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [WAY_BITS-1:0]  LAST_WAY = WAY_BITS'(WAYS - 1);

    logic                 valid_mem  [SETS][WAYS];
    logic [TAG_WIDTH-1:0] tag_mem    [SETS][WAYS];
    logic [PC_WIDTH-1:0]  target_mem [SETS][WAYS];
    logic [CNT_WIDTH-1:0] cnt_mem    [SETS][WAYS];
    logic [WAY_BITS-1:0]  rr_mem     [SETS];

    // Byte-offset bits never take part in indexing or tag compare.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {lookup_pc[1:0], update_pc[1:0]};

    // ---------------------------------------------------------------------------------------
    // Lookup
    // ---------------------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   lk_hit;
    logic [WAY_BITS-1:0]    lk_way;
    logic [CNT_WIDTH-1:0]   lk_cnt;

    assign lk_idx = lookup_pc[INDEX_WIDTH+1:2];
    assign lk_tag = lookup_pc[PC_WIDTH-1:INDEX_WIDTH+2];

    // Scan downward so the lowest-numbered matching way is the one left standing.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_BITS'(w);
            end
        end
    end

    assign lk_cnt      = cnt_mem[lk_idx][lk_way];
    assign pred_hit    = lk_hit;
    assign pred_taken  = lk_hit & lk_cnt[CNT_WIDTH-1];
    assign pred_target = pred_taken ? target_mem[lk_idx][lk_way] : lookup_pc_plus4;

    // ---------------------------------------------------------------------------------------
    // Update decode
    // ---------------------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] up_idx;
    logic [TAG_WIDTH-1:0]   up_tag;
    logic                   up_hit;
    logic [WAY_BITS-1:0]    up_way;
    logic                   has_free;
    logic [WAY_BITS-1:0]    free_way;
    logic [WAY_BITS-1:0]    victim;
    logic [CNT_WIDTH-1:0]   cur_cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [WAY_BITS-1:0]    rr_cur;
    logic [WAY_BITS-1:0]    rr_next;

    assign up_idx = update_pc[INDEX_WIDTH+1:2];
    assign up_tag = update_pc[PC_WIDTH-1:INDEX_WIDTH+2];

    always_comb begin
        up_hit   = 1'b0;
        up_way   = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[up_idx][w] && (tag_mem[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_BITS'(w);
            end
            if (!valid_mem[up_idx][w]) begin
                has_free = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
    end

    assign rr_cur  = rr_mem[up_idx];
    assign rr_next = (rr_cur == LAST_WAY) ? '0 : rr_cur + WAY_BITS'(1);
    assign victim  = has_free ? free_way : rr_cur;
    assign cur_cnt = cnt_mem[up_idx][up_way];

    always_comb begin
        cnt_next = cur_cnt;
        if (update_taken) begin
            if (cur_cnt != CNT_MAX) cnt_next = cur_cnt + CNT_WIDTH'(1);
        end else begin
            if (cur_cnt != '0) cnt_next = cur_cnt - CNT_WIDTH'(1);
        end
    end

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    // Tags and targets carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    cnt_mem[s][w]   <= '0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                rr_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                end
            end
        end else if (update_valid) begin
            if (up_hit) begin
                cnt_mem[up_idx][up_way] <= cnt_next;
                if (update_taken) begin
                    target_mem[up_idx][up_way] <= update_target;
                end
            end else if (update_taken) begin
                valid_mem[up_idx][victim]  <= 1'b1;
                tag_mem[up_idx][victim]    <= up_tag;
                target_mem[up_idx][victim] <= update_target;
                cnt_mem[up_idx][victim]    <= CNT_WEAK;
                // Pointer only moves when a live entry is thrown out.
                if (!has_free) begin
                    rr_mem[up_idx] <= rr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Directed, table-driven bench for btb_assoc_predictor at default parameters.
// Each vector is one cycle: outputs reflect state before that cycle's edge.
module tb_btb_assoc_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_pc_plus4;
    logic [31:0] pred_target;
    logic        pred_taken;
    logic        pred_hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        flush;

    int checks;
    int errors;

    btb_assoc_predictor #(
        .PC_WIDTH   (32),
        .INDEX_WIDTH(6),
        .WAYS       (2),
        .CNT_WIDTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .lookup_pc_plus4(lookup_pc_plus4),
        .pred_target    (pred_target),
        .pred_taken     (pred_taken),
        .pred_hit       (pred_hit),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] lpc;
        logic        ehit;
        logic        etak;
        logic [31:0] etgt;   // used only when etak; otherwise lpc+4 is expected
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic fl, input logic uv,
                                input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                                input logic [31:0] lpc, input logic ehit, input logic etak,
                                input logic [31:0] etgt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.lpc = lpc; v.ehit = ehit; v.etak = etak; v.etgt = etgt;
        vecs.push_back(v);
    endfunction

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        logic [31:0] exp_tgt;
        @(negedge clk);
        reset           = v.rst;
        flush           = v.fl;
        update_valid    = v.uv;
        update_pc       = v.upc;
        update_taken    = v.ut;
        update_target   = v.utgt;
        lookup_pc       = v.lpc;
        lookup_pc_plus4 = v.lpc + 32'd4;
        exp_tgt         = v.etak ? v.etgt : v.lpc + 32'd4;
        #1;
        check1({nm, " hit"}, pred_hit, v.ehit);
        check1({nm, " taken"}, pred_taken, v.etak);
        check32({nm, " target"}, pred_target, exp_tgt);
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt);
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        update_valid = 1'b1; update_pc = pc; update_taken = 1'b1; update_target = tgt;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        reset = 1'b1; flush = 1'b0; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; lookup_pc = 32'h40; lookup_pc_plus4 = 32'h44;
        repeat (2) @(posedge clk);

        //   rst fl  uv  upc            ut  utgt           lpc            hit tak etgt
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h40,        0, 0, 32'h0);   // 0 reset state
        add(0, 0, 1, 32'h40,        1, 32'h100,       32'h40,        0, 0, 32'h0);   // 1 no bypass
        add(0, 0, 1, 32'h40,        0, 32'h0,         32'h40,        1, 1, 32'h100); // 2 cnt2
        add(0, 0, 1, 32'h40,        0, 32'h0,         32'h40,        1, 0, 32'h0);   // 3 cnt1
        add(0, 0, 1, 32'h40,        0, 32'h0,         32'h40,        1, 0, 32'h0);   // 4 cnt0
        add(0, 0, 1, 32'h40,        1, 32'h180,       32'h40,        1, 0, 32'h0);   // 5 sat at 0
        add(0, 0, 1, 32'h40,        1, 32'h180,       32'h40,        1, 0, 32'h0);   // 6 cnt1
        add(0, 0, 1, 32'h40,        1, 32'h180,       32'h40,        1, 1, 32'h180); // 7 cnt2
        add(0, 0, 1, 32'h40,        1, 32'h180,       32'h40,        1, 1, 32'h180); // 8 cnt3
        add(0, 0, 1, 32'h40,        0, 32'hbad,       32'h40,        1, 1, 32'h180); // 9 sat at 3
        add(0, 0, 1, 32'h40,        0, 32'h0,         32'h40,        1, 1, 32'h180); // 10 nt keeps tgt
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h40,        1, 0, 32'h0);   // 11 cnt1
        add(1, 0, 0, 32'h0,         0, 32'h0,         32'h40,        1, 0, 32'h0);   // 12 reset
        add(0, 0, 1, 32'h40,        1, 32'h100,       32'h40,        0, 0, 32'h0);   // 13 -> way0
        add(0, 0, 1, 32'h140,       1, 32'h200,       32'h40,        1, 1, 32'h100); // 14 -> way1
        add(0, 0, 1, 32'h240,       1, 32'h300,       32'h140,       1, 1, 32'h200); // 15 evict w0
        add(0, 0, 1, 32'h40,        1, 32'h104,       32'h40,        0, 0, 32'h0);   // 16 evict w1
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h240,       1, 1, 32'h300); // 17
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h140,       0, 0, 32'h0);   // 18 evicted
        add(0, 0, 1, 32'h80,        0, 32'h0,         32'h40,        1, 1, 32'h104); // 19 nt miss
        add(0, 0, 1, 32'h340,       1, 32'h400,       32'h80,        0, 0, 32'h0);   // 20 no alloc
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h240,       0, 0, 32'h0);   // 21 rr wrap
        add(0, 1, 1, 32'h80,        1, 32'h500,       32'h340,       1, 1, 32'h400); // 22 flush+upd
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h80,        0, 0, 32'h0);   // 23 dropped
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h40,        0, 0, 32'h0);   // 24
        add(0, 0, 1, 32'h40,        1, 32'h600,       32'h340,       0, 0, 32'h0);   // 25 retrain
        add(0, 0, 1, 32'h140,       1, 32'h700,       32'h40,        1, 1, 32'h600); // 26
        add(0, 0, 1, 32'h240,       1, 32'h800,       32'h140,       1, 1, 32'h700); // 27 rr==0
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h40,        0, 0, 32'h0);   // 28
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h143,       1, 1, 32'h700); // 29 low bits
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h1000_0240, 0, 0, 32'h0);   // 30 tag diff
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h240,       1, 1, 32'h800); // 31
        add(1, 1, 1, 32'h40,        1, 32'h900,       32'h240,       1, 1, 32'h800); // 32 rst prio
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h40,        0, 0, 32'h0);   // 33
        add(0, 0, 0, 32'h0,         0, 32'h0,         32'h240,       0, 0, 32'h0);   // 34

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Populate several sets back to back, then flush and confirm every set misses.
        for (int i = 0; i < 4; i++) begin
            drive_update(32'h1000 + 32'(i * 4), 32'ha00 + 32'(i * 16));
        end
        @(negedge clk);
        update_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lookup_pc       = 32'h1000 + 32'(i * 4);
            lookup_pc_plus4 = lookup_pc + 32'd4;
            #1;
            check1($sformatf("fill%0d hit", i), pred_hit, 1'b1);
            check32($sformatf("fill%0d target", i), pred_target, 32'ha00 + 32'(i * 16));
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lookup_pc       = 32'h1000 + 32'(i * 4);
            lookup_pc_plus4 = lookup_pc + 32'd4;
            #1;
            check1($sformatf("flushed%0d hit", i), pred_hit, 1'b0);
            check32($sformatf("flushed%0d target", i), pred_target, lookup_pc + 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
